// File: rtl/missle_pool_ctl.sv
// missle_pool_ctl: pool of independent missile slots sharing one fire button.
// A button press launches the lowest-index free slot at the player's x
// position; flying slots climb STEP pixels per movement tick and retire at
// the top limit or when game logic reports a hit.
// Ports:
//   pclk, rst        clock, asynchronous active-high reset
//   xpos_in          player x position, captured at launch
//   missle_button    fire request (level, rising edge launches)
//   hit_in           per-slot collision, retires a flying slot
//   xpos_out/ypos_out per-slot positions, 12 bits per slot, slot i at [12i+:12]
//   on_out           per-slot flying flag
//   fire_out         one-cycle pulse per accepted launch
//   busy_out         all slots flying
module missle_pool_ctl #(
  parameter int unsigned N_MISSLES     = 4,
  parameter int unsigned COUNTER_LIMIT = 90000,
  parameter int unsigned STEP          = 1,
  parameter int unsigned Y_START       = 704,
  parameter int unsigned Y_MIN         = 80,
  parameter int unsigned COOLDOWN      = 4096
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic [11:0]             xpos_in,
  input  logic                    missle_button,
  input  logic [N_MISSLES-1:0]    hit_in,
  output logic [12*N_MISSLES-1:0] xpos_out,
  output logic [12*N_MISSLES-1:0] ypos_out,
  output logic [N_MISSLES-1:0]    on_out,
  output logic                    fire_out,
  output logic                    busy_out
);

  localparam int unsigned PW = 12;
  localparam int unsigned TW = (COUNTER_LIMIT < 1) ? 1 : $clog2(COUNTER_LIMIT + 1);
  localparam int unsigned CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [PW-1:0] Y_START_P = PW'(Y_START);
  // Lowest ypos that can still take a full step without passing Y_MIN
  localparam logic [PW-1:0] Y_FLOOR   = PW'(Y_MIN + STEP);
  localparam logic [PW-1:0] STEP_P    = PW'(STEP);

  typedef enum logic {IDLE = 1'b0, FLY = 1'b1} slot_state_e;

  slot_state_e          state_q [N_MISSLES];
  slot_state_e          state_d [N_MISSLES];
  logic [PW-1:0]        xpos_q  [N_MISSLES];
  logic [PW-1:0]        xpos_d  [N_MISSLES];
  logic [PW-1:0]        ypos_q  [N_MISSLES];
  logic [PW-1:0]        ypos_d  [N_MISSLES];
  logic [N_MISSLES-1:0] on_d;

  logic          button_q;
  logic          armed_q;
  logic [TW-1:0] tick_cnt_q;
  logic [CW-1:0] cool_q;
  logic [CW-1:0] cool_d;
  logic          fire_q;
  logic          busy_q;

  logic press;
  logic tick;
  logic any_idle;
  logic accept;
  logic launch_pending;

  // State register
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_MISSLES); i++) begin
        state_q[i] <= IDLE;
        xpos_q[i]  <= '0;
        ypos_q[i]  <= Y_START_P;
      end
      button_q   <= 1'b0;
      armed_q    <= 1'b0;
      tick_cnt_q <= '0;
      cool_q     <= '0;
      fire_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      button_q   <= missle_button;
      // Arms only once the button has been seen released, so a button held
      // through reset cannot fire on its first post-reset cycle.
      armed_q    <= armed_q | ~missle_button;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      cool_q     <= cool_d;
      fire_q     <= accept;
      busy_q     <= &on_d;
    end
  end

  // Launch arbitration, cooldown and per-slot next state
  always_comb begin
    press    = missle_button & ~button_q & armed_q;
    tick     = (tick_cnt_q == TW'(COUNTER_LIMIT));
    any_idle = 1'b0;
    for (int i = 0; i < int'(N_MISSLES); i++) begin
      if (state_q[i] == IDLE) any_idle = 1'b1;
    end
    accept = press & (cool_q == '0) & any_idle;

    if (accept)             cool_d = CW'(COOLDOWN);
    else if (cool_q != '0)  cool_d = cool_q - 1'b1;
    else                    cool_d = cool_q;

    // Cleared by the first IDLE slot that takes the launch (lowest index wins)
    launch_pending = accept;
    for (int i = 0; i < int'(N_MISSLES); i++) begin
      state_d[i] = state_q[i];
      xpos_d[i]  = xpos_q[i];
      ypos_d[i]  = ypos_q[i];
      case (state_q[i])
        FLY: begin
          if (hit_in[i]) begin
            state_d[i] = IDLE;
            ypos_d[i]  = Y_START_P;
          end else if (tick) begin
            if (ypos_q[i] >= Y_FLOOR) begin
              ypos_d[i] = ypos_q[i] - STEP_P;
            end else begin
              state_d[i] = IDLE;
              ypos_d[i]  = Y_START_P;
            end
          end
        end
        IDLE: begin
          if (launch_pending) begin
            state_d[i]     = FLY;
            xpos_d[i]      = xpos_in;
            ypos_d[i]      = Y_START_P;
            launch_pending = 1'b0;
          end
        end
        default: begin
          state_d[i] = IDLE;
        end
      endcase
      on_d[i] = (state_d[i] == FLY);
    end
  end

  // Output packing of registered slot state
  for (genvar g = 0; g < int'(N_MISSLES); g++) begin : g_out
    assign xpos_out[PW*g +: PW] = xpos_q[g];
    assign ypos_out[PW*g +: PW] = ypos_q[g];
    assign on_out[g]            = (state_q[g] == FLY);
  end

  assign fire_out = fire_q;
  assign busy_out = busy_q;

endmodule

// File: tb/tb_missle_pool_ctl.sv
// Testbench for missle_pool_ctl (2 slots, tick every 4 cycles, step 2,
// ypos 20 down to 10, cooldown 4). Table vectors, directed sequences and a
// random run against a cycle-level reference model.
module tb_missle_pool_ctl;

  localparam int N    = 2;
  localparam int LIM  = 3;
  localparam int STP  = 2;
  localparam int YS   = 20;
  localparam int YMIN = 10;
  localparam int CD   = 4;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic [11:0] xin  = '0;
  logic        btn  = 1'b0;
  logic [1:0]  hit  = '0;
  logic [23:0] xo;
  logic [23:0] yo;
  logic [1:0]  on;
  logic        fire;
  logic        busy;

  missle_pool_ctl #(
    .N_MISSLES(N), .COUNTER_LIMIT(LIM), .STEP(STP),
    .Y_START(YS), .Y_MIN(YMIN), .COOLDOWN(CD)
  ) u_dut (
    .pclk(pclk), .rst(rst), .xpos_in(xin), .missle_button(btn),
    .hit_in(hit), .xpos_out(xo), .ypos_out(yo), .on_out(on),
    .fire_out(fire), .busy_out(busy)
  );

  always #5 pclk = ~pclk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  // Reference model: elapsed cycles decide ticks and cooldown
  int cyc;
  int last_acc;
  bit prev_btn;
  bit m_fly [2];
  int m_x   [2];
  int m_y   [2];
  bit m_fire;

  task automatic model_reset();
    cyc      = 0;
    last_acc = -1000;
    prev_btn = 1'b1;   // level at reset is treated as already pressed
    for (int i = 0; i < N; i++) begin
      m_fly[i] = 1'b0;
      m_x[i]   = 0;
      m_y[i]   = YS;
    end
    m_fire = 1'b0;
  endtask

  task automatic step();
    bit press, tick, cool_ok, acc;
    int free;
    bit nf [2];
    int nx [2];
    int ny [2];
    press   = (btn == 1'b1) && !prev_btn;
    tick    = (cyc % (LIM + 1)) == LIM;
    cool_ok = (cyc - last_acc) > CD;
    nf = m_fly; nx = m_x; ny = m_y;
    for (int i = 0; i < N; i++) begin
      if (m_fly[i]) begin
        if (hit[i]) begin
          nf[i] = 1'b0; ny[i] = YS;
        end else if (tick) begin
          if (m_y[i] - STP < YMIN) begin
            nf[i] = 1'b0; ny[i] = YS;
          end else begin
            ny[i] = m_y[i] - STP;
          end
        end
      end
    end
    free = -1;
    for (int i = 0; i < N; i++) if (!m_fly[i] && free < 0) free = i;
    acc = press && cool_ok && (free >= 0);
    if (acc) begin
      nf[free] = 1'b1; nx[free] = int'(xin); ny[free] = YS; last_acc = cyc;
    end
    prev_btn = btn;
    cyc++;
    @(posedge pclk);
    #1;
    m_fly = nf; m_x = nx; m_y = ny; m_fire = acc;
    chk("model_on",   32'(on),   32'({m_fly[1], m_fly[0]}));
    chk("model_fire", 32'(fire), 32'(m_fire));
    chk("model_busy", 32'(busy), 32'(m_fly[0] & m_fly[1]));
    chk("model_x",    32'(xo),   32'({12'(m_x[1]), 12'(m_x[0])}));
    chk("model_y",    32'(yo),   32'({12'(m_y[1]), 12'(m_y[0])}));
  endtask

  // Reset asserted between edges; outputs must clear before the next edge
  task automatic do_reset(input bit hold);
    @(negedge pclk);
    #2;
    rst = 1'b1; btn = hold; hit = '0;
    #1;
    chk("rst_on",   32'(on),   32'd0);
    chk("rst_y",    32'(yo),   32'({12'(YS), 12'(YS)}));
    chk("rst_x",    32'(xo),   32'd0);
    chk("rst_fire", 32'(fire), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge pclk);
    rst = 1'b0;
    // Four idle cycles realign the tick phase to zero
    repeat (4) step();
  endtask

  typedef struct {
    logic        btn;
    logic [11:0] xin;
    logic [1:0]  hit;
    logic [1:0]  on;
    logic        fire;
    logic        busy;
    logic [11:0] x0;
    logic [11:0] y0;
  } vec_t;

  vec_t vt [24];

  function automatic vec_t mk(logic b, int x, int h, int o, logic f, logic bz, int x0, int y0);
    vec_t v;
    v.btn = b; v.xin = 12'(x); v.hit = 2'(h); v.on = 2'(o);
    v.fire = f; v.busy = bz; v.x0 = 12'(x0); v.y0 = 12'(y0);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cnt;
    // Single missile flight from launch to retirement at the top
    vt[0]  = mk(1, 100, 0, 1, 1, 0, 100, 20);
    vt[1]  = mk(0, 100, 0, 1, 0, 0, 100, 20);
    vt[2]  = mk(0, 100, 0, 1, 0, 0, 100, 20);
    vt[3]  = mk(0, 100, 0, 1, 0, 0, 100, 18);
    vt[4]  = mk(0, 100, 0, 1, 0, 0, 100, 18);
    vt[5]  = mk(0, 555, 0, 1, 0, 0, 100, 18);
    vt[6]  = mk(0, 100, 0, 1, 0, 0, 100, 18);
    vt[7]  = mk(0, 100, 0, 1, 0, 0, 100, 16);
    vt[8]  = mk(0, 100, 0, 1, 0, 0, 100, 16);
    vt[9]  = mk(0, 100, 0, 1, 0, 0, 100, 16);
    vt[10] = mk(0, 100, 0, 1, 0, 0, 100, 16);
    vt[11] = mk(0, 100, 0, 1, 0, 0, 100, 14);
    vt[12] = mk(0, 100, 0, 1, 0, 0, 100, 14);
    vt[13] = mk(0, 100, 0, 1, 0, 0, 100, 14);
    vt[14] = mk(0, 100, 0, 1, 0, 0, 100, 14);
    vt[15] = mk(0, 100, 0, 1, 0, 0, 100, 12);
    vt[16] = mk(0, 100, 0, 1, 0, 0, 100, 12);
    vt[17] = mk(0, 100, 0, 1, 0, 0, 100, 12);
    vt[18] = mk(0, 100, 0, 1, 0, 0, 100, 12);
    vt[19] = mk(0, 100, 0, 1, 0, 0, 100, 10);
    vt[20] = mk(0, 100, 2, 1, 0, 0, 100, 10);
    vt[21] = mk(0, 777, 0, 1, 0, 0, 100, 10);
    vt[22] = mk(0, 100, 0, 1, 0, 0, 100, 10);
    vt[23] = mk(0, 100, 0, 0, 0, 0, 100, 20);

    model_reset();
    do_reset(1'b0);
    for (int r = 0; r < 24; r++) begin
      btn = vt[r].btn; xin = vt[r].xin; hit = vt[r].hit;
      step();
      chk($sformatf("vec%0d_on", r),   32'(on),       32'(vt[r].on));
      chk($sformatf("vec%0d_fire", r), 32'(fire),     32'(vt[r].fire));
      chk($sformatf("vec%0d_busy", r), 32'(busy),     32'(vt[r].busy));
      chk($sformatf("vec%0d_x0", r),   32'(xo[11:0]), 32'(vt[r].x0));
      chk($sformatf("vec%0d_y0", r),   32'(yo[11:0]), 32'(vt[r].y0));
    end
    hit = '0;

    // Cooldown drop, second slot launch, pool full, hit on a tick cycle
    do_reset(1'b0);
    btn = 1; xin = 100; step();
    chk("seq_fire1", 32'(fire), 32'd1);
    chk("seq_on1",   32'(on),   32'd1);
    btn = 0; step();
    btn = 1; step();
    chk("seq_cool_drop", 32'(fire), 32'd0);
    chk("seq_cool_on",   32'(on),   32'd1);
    btn = 0; repeat (3) step();
    btn = 1; xin = 300; step();
    chk("seq_fire2", 32'(fire),       32'd1);
    chk("seq_on2",   32'(on),         32'd3);
    chk("seq_busy2", 32'(busy),       32'd1);
    chk("seq_x1",    32'(xo[23:12]),  32'd300);
    btn = 0; repeat (4) step();
    btn = 1; step();
    chk("seq_full_nofire", 32'(fire), 32'd0);
    chk("seq_full_busy",   32'(busy), 32'd1);
    chk("seq_full_on",     32'(on),   32'd3);
    btn = 0; repeat (3) step();
    hit = 2'b01; step();
    hit = 2'b00;
    chk("seq_hit_on", 32'(on),         32'd2);
    chk("seq_hit_y0", 32'(yo[11:0]),   32'd20);
    chk("seq_hit_y1", 32'(yo[23:12]),  32'd14);

    // Held button fires once
    do_reset(1'b0);
    btn = 1; cnt = 0;
    repeat (20) begin
      step();
      if (fire) cnt++;
    end
    chk("hold_fire_count", 32'(cnt), 32'd1);
    btn = 0; step();

    // Reset during flight with the button held through it
    do_reset(1'b0);
    btn = 1; xin = 55; step();
    chk("flight_fire", 32'(fire), 32'd1);
    repeat (5) step();
    do_reset(1'b1);
    step();
    chk("held_rst_nofire", 32'(fire), 32'd0);
    chk("held_rst_on",     32'(on),   32'd0);
    btn = 0; step();
    btn = 1; xin = 66; step();
    chk("repress_fire", 32'(fire),      32'd1);
    chk("repress_x0",   32'(xo[11:0]),  32'd66);

    // Random run against the reference model
    btn = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) btn = ~btn;
      xin = 12'($urandom);
      hit = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
